// File: rtl/sad_pkg.sv
// sad_pkg -- shared types and constants for the SAD motion-search controller.
//
// Contents:
//   sad_state_e   : controller FSM state encoding (IDLE, ISSUE, DRAIN, DONE)
//   SAD_W         : SAD accumulator width for the default 8-bit pixel datapath
//   SAD_MAX       : all-ones SAD value, used as the "no candidate yet" seed
//   sat_count()   : clamps a requested candidate count to the array size
package sad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sad_state_e;

    localparam int unsigned SAD_PIX_W = 8;
    localparam int unsigned SAD_W     = SAD_PIX_W + 5;
    localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

    // Requests beyond the candidate array size are clamped rather than
    // wrapped so a bad count can never index past the block memory.
    function automatic int unsigned sat_count(input int unsigned req,
                                              input int unsigned max_cnt);
        int unsigned res;
        if (req > max_cnt) begin
            res = max_cnt;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/sad_valid_pipe.sv
// sad_valid_pipe -- valid-bit shift register that mirrors the SAD datapath
// latency. A bit entered with in_valid in cycle t emerges on out_valid in
// cycle t+PIPE_LAT, which is exactly when that candidate's SAD is on sad_in.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (clears every stage)
//   in_valid  in   a candidate entered the datapath this cycle
//   out_valid out  the candidate entered PIPE_LAT cycles ago retires now
//   empty     out  no candidate is in flight
module sad_valid_pipe #(
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid,
    output logic empty
);

    logic [PIPE_LAT-1:0] vld_r;
    logic [PIPE_LAT-1:0] vld_s;

    // Next shift-register contents: older entries move up, newest at bit 0.
    always_comb begin
        vld_s    = vld_r << 1'b1;
        vld_s[0] = in_valid;
    end

    // Valid shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_r <= '0;
        end else begin
            vld_r <= vld_s;
        end
    end

    assign out_valid = vld_r[PIPE_LAT-1];
    assign empty     = ~|vld_r;

endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl -- sequences a block-matching search over up to NUM_CAND
// candidates, feeds candidate indices to the SAD datapath, and keeps the
// minimum returned SAD together with the index that produced it.
//
// Build option:
//   SAD_EARLY_EXIT_EN  when defined, a retired SAD of zero stops further
//                      issue (a perfect match cannot be beaten).
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   start       in   begin a search (looked at in IDLE only)
//   cand_count  in   number of candidates, 0..NUM_CAND (larger clamps)
//   cand_addr   out  candidate index presented to the candidate memory
//   issue       out  datapath inputs valid this cycle
//   sad_in      in   SAD result from the datapath (PIPE_LAT after issue)
//   best_sad    out  minimum SAD found
//   best_idx    out  candidate index of best_sad
//   busy        out  search in progress (ISSUE or DRAIN)
//   done        out  result valid, held until ack
//   ack         in   consumer acknowledge of done
module sad_search_ctrl
    import sad_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_CAND = 16,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [$clog2(NUM_CAND):0]   cand_count,
    output logic [$clog2(NUM_CAND)-1:0] cand_addr,
    output logic                        issue,
    input  logic [WIDTH+4:0]            sad_in,
    output logic [WIDTH+4:0]            best_sad,
    output logic [$clog2(NUM_CAND)-1:0] best_idx,
    output logic                        busy,
    output logic                        done,
    input  logic                        ack
);

    localparam int unsigned ADDR_W = $clog2(NUM_CAND);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned SW     = WIDTH + 5;
    localparam logic [SW-1:0]    SW_MAX  = {SW{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    sad_state_e          state_r, state_s;
    logic [CNT_W-1:0]    n_lat_r, n_lat_s;     // latched, clamped count
    logic [CNT_W-1:0]    iss_cnt_r, iss_cnt_s; // candidates issued so far
    logic [CNT_W-1:0]    ret_cnt_r, ret_cnt_s; // candidates retired so far
    logic                issue_r, issue_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [SW-1:0]       best_sad_r, best_sad_s;
    logic [ADDR_W-1:0]   best_idx_r, best_idx_s;

    logic                pipe_out_s;
    logic                pipe_empty_s;
    logic                retire_s;
    logic                early_stop_s;
    logic                drained_s;
    logic [CNT_W-1:0]    count_sat_s;

    sad_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_r),
        .out_valid (pipe_out_s),
        .empty     (pipe_empty_s)
    );

    // Retire qualification, clamp of the request and drain-completion test.
    always_comb begin
        retire_s    = pipe_out_s && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN));
        count_sat_s = CNT_W'(sat_count(32'(cand_count), NUM_CAND));
        // The final retire and the move to DONE share one edge, which is
        // what makes the start-to-done latency N+PIPE_LAT+1.
        drained_s   = (retire_s && ((ret_cnt_r + CNT_ONE) == iss_cnt_r)) || pipe_empty_s;
`ifdef SAD_EARLY_EXIT_EN
        early_stop_s = retire_s && (sad_in == {SW{1'b0}});
`else
        early_stop_s = 1'b0;
`endif
    end

    // FSM next state and next values of every registered output.
    always_comb begin
        state_s    = state_r;
        n_lat_s    = n_lat_r;
        iss_cnt_s  = iss_cnt_r;
        ret_cnt_s  = ret_cnt_r;
        issue_s    = issue_r;
        busy_s     = busy_r;
        done_s     = done_r;
        best_sad_s = best_sad_r;
        best_idx_s = best_idx_r;

        // Strict compare: on a tie the earlier (lower) index is kept. The
        // retire index has its own counter so it is independent of cand_addr.
        if (retire_s) begin
            ret_cnt_s = ret_cnt_r + CNT_ONE;
            if (sad_in < best_sad_r) begin
                best_sad_s = sad_in;
                best_idx_s = ret_cnt_r[ADDR_W-1:0];
            end else begin
                best_sad_s = best_sad_r;
            end
        end else begin
            ret_cnt_s = ret_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    n_lat_s    = count_sat_s;
                    iss_cnt_s  = {CNT_W{1'b0}};
                    ret_cnt_s  = {CNT_W{1'b0}};
                    best_sad_s = SW_MAX;
                    best_idx_s = {ADDR_W{1'b0}};
                    if (count_sat_s != {CNT_W{1'b0}}) begin
                        state_s = ST_ISSUE;
                        issue_s = 1'b1;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // This cycle's candidate counts as issued even when it is the
                // one that triggers an early stop.
                iss_cnt_s = iss_cnt_r + CNT_ONE;
                if ((iss_cnt_r == (n_lat_r - CNT_ONE)) || early_stop_s) begin
                    state_s = ST_DRAIN;
                    issue_s = 1'b0;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (drained_s) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                issue_s = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            n_lat_r    <= '0;
            iss_cnt_r  <= '0;
            ret_cnt_r  <= '0;
            issue_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            best_sad_r <= '0;
            best_idx_r <= '0;
        end else begin
            state_r    <= state_s;
            n_lat_r    <= n_lat_s;
            iss_cnt_r  <= iss_cnt_s;
            ret_cnt_r  <= ret_cnt_s;
            issue_r    <= issue_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            best_sad_r <= best_sad_s;
            best_idx_r <= best_idx_s;
        end
    end

    assign cand_addr = iss_cnt_r[ADDR_W-1:0];
    assign issue     = issue_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign best_sad  = best_sad_r;
    assign best_idx  = best_idx_r;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Self-checking bench for sad_search_ctrl: directed table, hand sequences
// for reset / early exit, and randomized searches against a reference model.
module tb_sad_search_ctrl;

    localparam int WIDTH    = 8;
    localparam int NUM_CAND = 16;
    localparam int PIPE_LAT = 3;
    localparam int AW       = 4;
    localparam int SW       = 13;
    localparam int SMAX     = 8191;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic [AW:0]   cand_count = '0;
    logic [SW-1:0] sad_in = '0;
    logic [AW-1:0] cand_addr;
    logic [AW-1:0] best_idx;
    logic [SW-1:0] best_sad;
    logic          issue;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_v[NUM_CAND];
    int sched_v[400];
    bit sched_ok[400];

    typedef struct {
        string name;
        int    n_req;
        int    vals[NUM_CAND];
        int    exp_sad;
        int    exp_idx;
        int    exp_lat;
        int    exp_iss;
        int    hold;
        int    ack_start;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    sad_search_ctrl #(
        .WIDTH    (WIDTH),
        .NUM_CAND (NUM_CAND),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cand_count (cand_count),
        .cand_addr  (cand_addr),
        .issue      (issue),
        .sad_in     (sad_in),
        .best_sad   (best_sad),
        .best_idx   (best_idx),
        .busy       (busy),
        .done       (done),
        .ack        (ack)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: the smallest value among the first n candidates, earliest
    // index on ties; all-ones and index 0 when nothing beats the seed.
    task automatic model(input int n_req, output int n, output int bs, output int bi);
        n  = (n_req > NUM_CAND) ? NUM_CAND : n_req;
        bs = SMAX;
        bi = 0;
        for (int i = 0; i < n; i++) begin
            if (mem_v[i] < bs) begin
                bs = mem_v[i];
                bi = i;
            end
        end
    endtask

    // One complete search. The bench plays the candidate memory + datapath:
    // the SAD for the address seen on an issue cycle appears PIPE_LAT later.
    task automatic run_search(input string name, input int n_req, input int exp_sad,
                              input int exp_idx, input int exp_lat, input int exp_iss,
                              input int pulse_cyc, input int hold, input int ack_start);
        int iss_cnt;
        int addr_err;
        int busy_err;
        int done_cyc;
        bit busy_exp;
        for (int i = 0; i < 400; i++) sched_ok[i] = 1'b0;
        busy_exp   = (n_req != 0);
        cand_count = 5'(n_req);
        start      = 1'b1;
        sad_in     = '0;
        step();
        start    = 1'b0;
        iss_cnt  = 0;
        addr_err = 0;
        busy_err = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc < 300; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (issue) begin
                if (int'(cand_addr) != (iss_cnt % NUM_CAND)) addr_err++;
                sched_v[cyc + PIPE_LAT]  = mem_v[cand_addr];
                sched_ok[cyc + PIPE_LAT] = 1'b1;
                iss_cnt++;
            end
            if (busy !== busy_exp) busy_err++;
            if (cyc == pulse_cyc) begin
                start      = 1'b1;
                ack        = 1'b1;
                cand_count = 5'd2;
            end else begin
                start = 1'b0;
                ack   = 1'b0;
            end
            sad_in = sched_ok[cyc] ? SW'(sched_v[cyc]) : '0;
            step();
        end
        start  = 1'b0;
        ack    = 1'b0;
        sad_in = '0;
        chk({name, ".done_reached"}, int'(done_cyc >= 0), 1);
        if (exp_lat >= 0) chk({name, ".latency"}, done_cyc, exp_lat);
        chk({name, ".best_sad"}, int'(best_sad), exp_sad);
        chk({name, ".best_idx"}, int'(best_idx), exp_idx);
        chk({name, ".issues"}, iss_cnt, exp_iss);
        chk({name, ".addr_seq_err"}, addr_err, 0);
        chk({name, ".busy_err"}, busy_err, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({name, ".done_held"}, int'(done), 1);
            chk({name, ".sad_held"}, int'(best_sad), exp_sad);
        end
        ack   = 1'b1;
        start = ack_start[0];
        step();
        ack   = 1'b0;
        start = 1'b0;
        chk({name, ".done_after_ack"}, int'(done), 0);
        chk({name, ".busy_after_ack"}, int'(busy), 0);
        step();
        chk({name, ".idle_issue"}, int'(issue), 0);
        chk({name, ".idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        int bs;
        int bi;
        int lat;

        // Directed table.
        for (int e = 0; e < 7; e++) begin
            for (int i = 0; i < NUM_CAND; i++) tbl[e].vals[i] = 0;
            tbl[e].hold = 0;
            tbl[e].ack_start = 0;
        end
        tbl[0].name = "n4";      tbl[0].n_req = 4;
        tbl[0].vals[0] = 50; tbl[0].vals[1] = 20; tbl[0].vals[2] = 30; tbl[0].vals[3] = 40;
        tbl[0].exp_sad = 20;     tbl[0].exp_idx = 1;  tbl[0].exp_lat = 8;  tbl[0].exp_iss = 4;
        tbl[1].name = "tie";     tbl[1].n_req = 3;
        tbl[1].vals[0] = 7; tbl[1].vals[1] = 7; tbl[1].vals[2] = 9;
        tbl[1].exp_sad = 7;      tbl[1].exp_idx = 0;  tbl[1].exp_lat = 7;  tbl[1].exp_iss = 3;
        tbl[1].hold = 5;         tbl[1].ack_start = 1;
        tbl[2].name = "n0";      tbl[2].n_req = 0;
        tbl[2].exp_sad = SMAX;   tbl[2].exp_idx = 0;  tbl[2].exp_lat = 1;  tbl[2].exp_iss = 0;
        tbl[2].hold = 2;
        tbl[3].name = "sat20";   tbl[3].n_req = 20;
        for (int i = 0; i < NUM_CAND; i++) tbl[3].vals[i] = 200 - 5 * i;
        tbl[3].exp_sad = 125;    tbl[3].exp_idx = 15; tbl[3].exp_lat = 20; tbl[3].exp_iss = 16;
        tbl[4].name = "equal16"; tbl[4].n_req = 16;
        for (int i = 0; i < NUM_CAND; i++) tbl[4].vals[i] = 42;
        tbl[4].exp_sad = 42;     tbl[4].exp_idx = 0;  tbl[4].exp_lat = 20; tbl[4].exp_iss = 16;
        tbl[5].name = "max1";    tbl[5].n_req = 1;
        tbl[5].vals[0] = SMAX;
        tbl[5].exp_sad = SMAX;   tbl[5].exp_idx = 0;  tbl[5].exp_lat = 5;  tbl[5].exp_iss = 1;
        tbl[6].name = "zero2";   tbl[6].n_req = 2;
        tbl[6].exp_sad = 0;      tbl[6].exp_idx = 0;  tbl[6].exp_lat = 6;  tbl[6].exp_iss = 2;
        tbl[6].ack_start = 1;

        // Reset state.
        #2;
        chk("rst.issue", int'(issue), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.best_sad", int'(best_sad), 0);
        step();
        step();
        rst = 1'b1;
        step();

        for (int e = 0; e < 7; e++) begin
            for (int i = 0; i < NUM_CAND; i++) mem_v[i] = tbl[e].vals[i];
            run_search(tbl[e].name, tbl[e].n_req, tbl[e].exp_sad, tbl[e].exp_idx,
                       tbl[e].exp_lat, tbl[e].exp_iss, 0, tbl[e].hold, tbl[e].ack_start);
        end

        // start/ack pulsed during ISSUE with an over-range count: ignored.
        for (int i = 0; i < NUM_CAND; i++) mem_v[i] = 300 - i;
        mem_v[6] = 11;
        run_search("start_in_issue", 20, 11, 6, 20, 16, 3, 1, 0);

        // Reset in the middle of a 16-candidate search.
        for (int i = 0; i < NUM_CAND; i++) mem_v[i] = 5;
        cand_count = 5'd16;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("midrst.pre_issue", int'(issue), 1);
        rst = 1'b0;
        #1;
        chk("midrst.issue", int'(issue), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.addr", int'(cand_addr), 0);
        chk("midrst.best_sad", int'(best_sad), 0);
        chk("midrst.best_idx", int'(best_idx), 0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("midrst.idle_busy", int'(busy), 0);
        mem_v[0] = 3;
        mem_v[1] = 1;
        run_search("after_rst", 2, 1, 1, 6, 2, 0, 0, 0);

        // A zero SAD on the second retire.
        for (int i = 0; i < NUM_CAND; i++) mem_v[i] = 100 + i;
        mem_v[0] = 500;
        mem_v[1] = 0;
`ifdef SAD_EARLY_EXIT_EN
        run_search("zero_exit", 16, 0, 1, 9, 5, 0, 0, 0);
`else
        run_search("zero_exit", 16, 0, 1, 20, 16, 0, 0, 0);
`endif

        // Randomized searches against the reference model.
        for (int r = 0; r < 25; r++) begin
            int n_req;
            n_req = int'($urandom_range(0, 20));
            for (int i = 0; i < NUM_CAND; i++) begin
                if ($urandom_range(0, 1) == 1) mem_v[i] = int'($urandom_range(1, SMAX));
                else mem_v[i] = int'($urandom_range(1, 6));
            end
            model(n_req, n, bs, bi);
            lat = (n == 0) ? 1 : n + PIPE_LAT + 1;
            run_search("rand", n_req, bs, bi, lat, n, int'($urandom_range(1, 6)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel width of the SAD datapath.
REQ-002 SHALL have parameter NUM_CAND, default 16, maximum candidates per search (power of 2, >=2).
REQ-003 SHALL have parameter PIPE_LAT, default 3, cycles from datapath input to out_sad (>=1).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a search; sampled in IDLE only.
- cand_count  in  clog2(NUM_CAND)+1  candidates to evaluate; 0..NUM_CAND.
- cand_addr  out  clog2(NUM_CAND)  candidate index presented to the block memory feeding can_0..can_31.
- issue  out  1  datapath inputs valid this cycle.
- sad_in  in  WIDTH+5  datapath out_sad.
- best_sad  out  WIDTH+5  minimum SAD found.
- best_idx  out  clog2(NUM_CAND)  index of best_sad.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  result valid, held until ack.
- ack  in  1  consumer acknowledge.

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE; outputs are registered.
REQ-006 IDLE: start=1 and cand_count>0 -> ISSUE; start=1 and cand_count=0 -> DONE with best_sad=all ones and best_idx=0; cand_count latched on start.
REQ-007 On leaving IDLE, best_sad SHALL load all ones (2^(WIDTH+5)-1), best_idx 0, issue counter 0.
REQ-008 ISSUE: issue=1, cand_addr=counter for each of N consecutive cycles (N = latched count), counter +1 per cycle; after cycle with counter=N-1 -> DRAIN.
REQ-009 A PIPE_LAT-deep valid shift register SHALL track issue; the retire strobe for the candidate issued in cycle t is asserted in cycle t+PIPE_LAT, and sad_in is sampled then.
REQ-010 On retire, if sad_in < best_sad (strictly), best_sad<=sad_in and best_idx<=retired index; ties keep the lower index.
REQ-011 The retired index SHALL be a separate counter incremented on every retire, not derived from cand_addr.
REQ-012 DRAIN: issue=0; when the valid register is empty and the last retire has been processed -> DONE; start-to-done latency for N candidates SHALL be exactly N+PIPE_LAT+1 cycles.
REQ-013 DONE: done=1, best_sad/best_idx stable; ack=1 -> IDLE (done low next cycle); ack outside DONE ignored.
REQ-014 start while busy or done SHALL be ignored; start and ack both high in DONE: ack honoured, start ignored.
REQ-015 cand_count > NUM_CAND SHALL saturate to NUM_CAND.

Reset
REQ-016 rst low SHALL asynchronously force IDLE, issue=0, busy=0, done=0, cand_addr=0, best_sad=0, best_idx=0, and clear the valid shift register and all counters.
REQ-017 Reset mid-search SHALL discard all in-flight results; after rst high, no retire occurs until a new start.

Configuration
REQ-018 Macro SAD_EARLY_EXIT_EN defined: a retire with sad_in=0 SHALL record it, stop further issue the next cycle and go to DRAIN; in-flight results still retire but cannot replace it (ties).
REQ-019 Macro SAD_EARLY_EXIT_EN undefined: all N candidates are always issued; no zero detection logic exists.

Structure
REQ-020 Package sad_pkg SHALL hold the FSM state typedef, SAD_W = WIDTH+5 and SAD_MAX (all ones) constants.
REQ-021 The valid/retire shift register SHALL be sub-module sad_valid_pipe (parameter PIPE_LAT; in: clk, rst, in_valid; out: out_valid, empty).

Verification
REQ-022 N=4, PIPE_LAT=3, sad_in per retire 50,20,30,40 -> best_sad=20, best_idx=1, done in cycle 8 after start.
REQ-023 N=3, sad_in 7,7,9 -> best_idx=0 (tie keeps lower); done held 5 cycles without ack, then ack -> IDLE next cycle.
REQ-024 cand_count=0 -> DONE after one cycle, best_sad=8191 (WIDTH=8), best_idx=0, issue never asserted.
REQ-025 N=16, rst low after the 5th issue cycle -> all outputs at reset values immediately; new start N=2 with sad_in 3,1 -> best_sad=1, best_idx=1.
REQ-026 SAD_EARLY_EXIT_EN, N=16, second retire sad_in=0 -> issue stops, best_sad=0, best_idx=1, fewer than 16 issue cycles; without the macro, exactly 16 issue cycles.
REQ-027 start pulsed during ISSUE and cand_count=20 (NUM_CAND=16) -> start ignored; 16 issue cycles.
